// File: rtl/ovl_fire_monitor.sv
// ovl_fire_monitor: consumer of an OVL checker fire bus. Keeps saturating
// per-class event counters, first/last failure timestamps and a sticky
// failure threshold flag, giving one cycle-accurate summary per checker.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous active-high reset
//   enable         monitor enable; counting only while high
//   fire[2:0]      [0] assertion fail, [1] cover, [2] X-check
//   clear          single-cycle pulse; zeroes counters, timestamps, flags
//   state          FSM state: 0 IDLE, 1 ARMED, 2 TRIPPED, 3 FROZEN
//   cycle_count    cycles spent counting in ARMED/TRIPPED (saturating)
//   fail_count     cycles with fire[0] set (saturating)
//   cover_count    cycles with fire[1] set (saturating)
//   xchk_count     cycles with fire[2] set (saturating)
//   first_fail_ts  cycle_count at the first counted fail
//   last_fail_ts   cycle_count at the most recent counted fail
//   fail_seen      sticky, set by the first counted fail
//   threshold_hit  sticky, set once fail_count >= MAX_FAIL
module ovl_fire_monitor #(
   parameter int unsigned CNT_WIDTH    = 16,
   parameter int unsigned TS_WIDTH     = 32,
   parameter int unsigned MAX_FAIL     = 1,
   parameter bit          HALT_ON_TRIP = 1'b0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           fire,
   input  logic                 clear,
   output logic [1:0]           state,
   output logic [TS_WIDTH-1:0]  cycle_count,
   output logic [CNT_WIDTH-1:0] fail_count,
   output logic [CNT_WIDTH-1:0] cover_count,
   output logic [CNT_WIDTH-1:0] xchk_count,
   output logic [TS_WIDTH-1:0]  first_fail_ts,
   output logic [TS_WIDTH-1:0]  last_fail_ts,
   output logic                 fail_seen,
   output logic                 threshold_hit
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_TRIPPED = 2'd2,
      ST_FROZEN  = 2'd3
   } state_e;

   localparam logic [CNT_WIDTH-1:0] CntMax  = '1;
   localparam logic [TS_WIDTH-1:0]  TsMax   = '1;
   localparam logic [CNT_WIDTH-1:0] MaxFail = CNT_WIDTH'(MAX_FAIL);

   state_e                state_q,     state_d;
   logic [TS_WIDTH-1:0]   cycle_q,     cycle_d;
   logic [CNT_WIDTH-1:0]  fail_q,      fail_d;
   logic [CNT_WIDTH-1:0]  cover_q,     cover_d;
   logic [CNT_WIDTH-1:0]  xchk_q,      xchk_d;
   logic [TS_WIDTH-1:0]   first_ts_q,  first_ts_d;
   logic [TS_WIDTH-1:0]   last_ts_q,   last_ts_d;
   logic                  fail_seen_q, fail_seen_d;
   logic                  thresh_q,    thresh_d;

   logic [2:0]            fire_v;
   logic                  count_en;

   // Counter increment that holds at all ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CntMax) ? v : v + CNT_WIDTH'(1);
   endfunction

   // Next-state and datapath update; clear has priority over counting.
   always_comb begin
      state_d     = state_q;
      cycle_d     = cycle_q;
      fail_d      = fail_q;
      cover_d     = cover_q;
      xchk_d      = xchk_q;
      first_ts_d  = first_ts_q;
      last_ts_d   = last_ts_q;
      fail_seen_d = fail_seen_q;
      thresh_d    = thresh_q;
      fire_v      = 3'b000;
      count_en    = 1'b0;

      // Unknown fire bits fall through to the 0 default.
      for (int i = 0; i < 3; i++) begin
         if (fire[i]) fire_v[i] = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = thresh_q ? ST_TRIPPED : ST_ARMED;
         end
         ST_ARMED, ST_TRIPPED: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else begin
               count_en = 1'b1;
               if ((state_q == ST_TRIPPED) && HALT_ON_TRIP) state_d = ST_FROZEN;
            end
         end
         ST_FROZEN: begin
            state_d = ST_FROZEN;
         end
      endcase

      if (count_en) begin
         if (cycle_q != TsMax) cycle_d = cycle_q + TS_WIDTH'(1);
         if (fire_v[0]) begin
            fail_d      = sat_inc(fail_q);
            last_ts_d   = cycle_q;
            fail_seen_d = 1'b1;
            if (!fail_seen_q) first_ts_d = cycle_q;
         end
         if (fire_v[1]) cover_d = sat_inc(cover_q);
         if (fire_v[2]) xchk_d  = sat_inc(xchk_q);
         if (fail_d >= MaxFail) thresh_d = 1'b1;
         if (thresh_d && (state_q == ST_ARMED)) state_d = ST_TRIPPED;
      end

      if (clear) begin
         state_d     = enable ? ST_ARMED : ST_IDLE;
         cycle_d     = '0;
         fail_d      = '0;
         cover_d     = '0;
         xchk_d      = '0;
         first_ts_d  = '0;
         last_ts_d   = '0;
         fail_seen_d = 1'b0;
         thresh_d    = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cycle_q     <= '0;
         fail_q      <= '0;
         cover_q     <= '0;
         xchk_q      <= '0;
         first_ts_q  <= '0;
         last_ts_q   <= '0;
         fail_seen_q <= 1'b0;
         thresh_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cycle_q     <= cycle_d;
         fail_q      <= fail_d;
         cover_q     <= cover_d;
         xchk_q      <= xchk_d;
         first_ts_q  <= first_ts_d;
         last_ts_q   <= last_ts_d;
         fail_seen_q <= fail_seen_d;
         thresh_q    <= thresh_d;
      end
   end

   assign state         = state_q;
   assign cycle_count   = cycle_q;
   assign fail_count    = fail_q;
   assign cover_count   = cover_q;
   assign xchk_count    = xchk_q;
   assign first_fail_ts = first_ts_q;
   assign last_fail_ts  = last_ts_q;
   assign fail_seen     = fail_seen_q;
   assign threshold_hit = thresh_q;

endmodule

// File: tb/tb_ovl_fire_monitor.sv
// Directed bench for ovl_fire_monitor: three instances cover the default
// configuration, a halting threshold of 3, and narrow 4-bit counters.
module tb_ovl_fire_monitor;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // ---------------- instance A: defaults (MAX_FAIL=1, no halt) ----------
   logic        rst_a, en_a, clr_a;
   logic [2:0]  fire_a;
   logic [1:0]  st_a;
   logic [31:0] cyc_a, fts_a, lts_a;
   logic [15:0] fail_a, cov_a, xc_a;
   logic        seen_a, thr_a;

   ovl_fire_monitor u_a (
      .clock(clock), .reset(rst_a), .enable(en_a), .fire(fire_a), .clear(clr_a),
      .state(st_a), .cycle_count(cyc_a), .fail_count(fail_a), .cover_count(cov_a),
      .xchk_count(xc_a), .first_fail_ts(fts_a), .last_fail_ts(lts_a),
      .fail_seen(seen_a), .threshold_hit(thr_a)
   );

   // ---------------- instance B: MAX_FAIL=3, HALT_ON_TRIP=1 --------------
   logic        rst_b, en_b, clr_b;
   logic [2:0]  fire_b;
   logic [1:0]  st_b;
   logic [31:0] cyc_b, fts_b, lts_b;
   logic [15:0] fail_b, cov_b, xc_b;
   logic        seen_b, thr_b;

   ovl_fire_monitor #(.MAX_FAIL(3), .HALT_ON_TRIP(1'b1)) u_b (
      .clock(clock), .reset(rst_b), .enable(en_b), .fire(fire_b), .clear(clr_b),
      .state(st_b), .cycle_count(cyc_b), .fail_count(fail_b), .cover_count(cov_b),
      .xchk_count(xc_b), .first_fail_ts(fts_b), .last_fail_ts(lts_b),
      .fail_seen(seen_b), .threshold_hit(thr_b)
   );

   // ---------------- instance C: CNT_WIDTH=4 -----------------------------
   logic        rst_c, en_c, clr_c;
   logic [2:0]  fire_c;
   logic [1:0]  st_c;
   logic [31:0] cyc_c, fts_c, lts_c;
   logic [3:0]  fail_c, cov_c, xc_c;
   logic        seen_c, thr_c;

   ovl_fire_monitor #(.CNT_WIDTH(4)) u_c (
      .clock(clock), .reset(rst_c), .enable(en_c), .fire(fire_c), .clear(clr_c),
      .state(st_c), .cycle_count(cyc_c), .fail_count(fail_c), .cover_count(cov_c),
      .xchk_count(xc_c), .first_fail_ts(fts_c), .last_fail_ts(lts_c),
      .fail_seen(seen_c), .threshold_hit(thr_c)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle past the edge before sampling.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      rst_a = 1'b1; en_a = 1'b0; clr_a = 1'b0; fire_a = 3'b000;
      rst_b = 1'b1; en_b = 1'b0; clr_b = 1'b0; fire_b = 3'b000;
      rst_c = 1'b1; en_c = 1'b0; clr_c = 1'b0; fire_c = 3'b000;
      tick();

      // ================= A: reset, arm, single fail trips =================
      check_eq("a_rst_state", 32'(st_a), 32'd0);
      check_eq("a_rst_cycle", cyc_a, 32'd0);
      check_eq("a_rst_fail",  32'(fail_a), 32'd0);
      check_eq("a_rst_thr",   32'(thr_a), 32'd0);
      rst_a = 1'b0; en_a = 1'b1;
      tick();
      check_eq("a_armed", 32'(st_a), 32'd1);
      check_eq("a_arm_cycle", cyc_a, 32'd0);
      repeat (5) tick();
      check_eq("a_cycle5", cyc_a, 32'd5);
      check_eq("a_c5_fail", 32'(fail_a), 32'd0);
      check_eq("a_c5_seen", 32'(seen_a), 32'd0);
      check_eq("a_c5_fts",  fts_a, 32'd0);
      repeat (2) tick();
      fire_a = 3'b001;
      tick();
      check_eq("a_f1_fts",   fts_a, 32'd7);
      check_eq("a_f1_lts",   lts_a, 32'd7);
      check_eq("a_f1_fail",  32'(fail_a), 32'd1);
      check_eq("a_f1_thr",   32'(thr_a), 32'd1);
      check_eq("a_f1_seen",  32'(seen_a), 32'd1);
      check_eq("a_f1_state", 32'(st_a), 32'd2);
      check_eq("a_f1_cycle", cyc_a, 32'd8);
      // TRIPPED without halt keeps counting; only last_fail_ts moves
      tick();
      check_eq("a_f2_fail",  32'(fail_a), 32'd2);
      check_eq("a_f2_fts",   fts_a, 32'd7);
      check_eq("a_f2_lts",   lts_a, 32'd8);
      check_eq("a_f2_state", 32'(st_a), 32'd2);

      // clear wins over fire in the same cycle
      fire_a = 3'b111; clr_a = 1'b1;
      tick();
      check_eq("a_clr_state", 32'(st_a), 32'd1);
      check_eq("a_clr_cycle", cyc_a, 32'd0);
      check_eq("a_clr_fail",  32'(fail_a), 32'd0);
      check_eq("a_clr_cov",   32'(cov_a), 32'd0);
      check_eq("a_clr_xc",    32'(xc_a), 32'd0);
      check_eq("a_clr_lts",   lts_a, 32'd0);
      check_eq("a_clr_thr",   32'(thr_a), 32'd0);
      check_eq("a_clr_seen",  32'(seen_a), 32'd0);
      fire_a = 3'b110; clr_a = 1'b0;
      tick();
      check_eq("a_110_cov",  32'(cov_a), 32'd1);
      check_eq("a_110_xc",   32'(xc_a), 32'd1);
      check_eq("a_110_fail", 32'(fail_a), 32'd0);
      check_eq("a_110_cyc",  cyc_a, 32'd1);

      // drop enable: fire of that cycle is not counted, values held
      en_a = 1'b0; fire_a = 3'b111;
      tick();
      check_eq("a_dis_state", 32'(st_a), 32'd0);
      check_eq("a_dis_cov",   32'(cov_a), 32'd1);
      check_eq("a_dis_fail",  32'(fail_a), 32'd0);
      check_eq("a_dis_cyc",   cyc_a, 32'd1);
      tick();
      check_eq("a_idle_cyc",  cyc_a, 32'd1);
      en_a = 1'b1; fire_a = 3'b010;
      tick();
      check_eq("a_ren_state", 32'(st_a), 32'd1);
      check_eq("a_ren_cov",   32'(cov_a), 32'd1);
      tick();
      check_eq("a_res_cov",   32'(cov_a), 32'd2);
      check_eq("a_res_cyc",   cyc_a, 32'd2);
      fire_a = 3'b001;
      tick();
      check_eq("a_f3_fts",   fts_a, 32'd2);
      check_eq("a_f3_state", 32'(st_a), 32'd2);
      check_eq("a_f3_cov",   32'(cov_a), 32'd2);
      // re-enable with threshold already hit lands in TRIPPED
      en_a = 1'b0; fire_a = 3'b000;
      tick();
      check_eq("a_dis2_state", 32'(st_a), 32'd0);
      check_eq("a_dis2_thr",   32'(thr_a), 32'd1);
      en_a = 1'b1;
      tick();
      check_eq("a_ren2_state", 32'(st_a), 32'd2);
      check_eq("a_ren2_cyc",   cyc_a, 32'd3);
      // reset overrides enable and fire
      rst_a = 1'b1; fire_a = 3'b111;
      tick();
      check_eq("a_rst2_state", 32'(st_a), 32'd0);
      check_eq("a_rst2_cyc",   cyc_a, 32'd0);
      check_eq("a_rst2_fail",  32'(fail_a), 32'd0);
      check_eq("a_rst2_cov",   32'(cov_a), 32'd0);
      check_eq("a_rst2_fts",   fts_a, 32'd0);
      check_eq("a_rst2_lts",   lts_a, 32'd0);
      check_eq("a_rst2_seen",  32'(seen_a), 32'd0);
      check_eq("a_rst2_thr",   32'(thr_a), 32'd0);

      // ================= B: threshold 3 with halt =================
      rst_b = 1'b0; en_b = 1'b1;
      tick();
      check_eq("b_armed", 32'(st_b), 32'd1);
      repeat (2) tick();
      fire_b = 3'b001; tick();
      check_eq("b_f1_fts",   fts_b, 32'd2);
      check_eq("b_f1_state", 32'(st_b), 32'd1);
      fire_b = 3'b000; tick();
      fire_b = 3'b001; tick();
      check_eq("b_f2_lts",   lts_b, 32'd4);
      check_eq("b_f2_thr",   32'(thr_b), 32'd0);
      fire_b = 3'b000; tick();
      fire_b = 3'b001; tick();
      check_eq("b_f3_fail",  32'(fail_b), 32'd3);
      check_eq("b_f3_thr",   32'(thr_b), 32'd1);
      check_eq("b_f3_state", 32'(st_b), 32'd2);
      check_eq("b_f3_cyc",   cyc_b, 32'd7);
      fire_b = 3'b000; tick();
      check_eq("b_frz_state", 32'(st_b), 32'd3);
      check_eq("b_frz_cyc",   cyc_b, 32'd8);
      fire_b = 3'b111;
      repeat (3) tick();
      check_eq("b_frz_fail",  32'(fail_b), 32'd3);
      check_eq("b_frz_lts",   lts_b, 32'd6);
      check_eq("b_frz_fts",   fts_b, 32'd2);
      check_eq("b_frz_cov",   32'(cov_b), 32'd0);
      check_eq("b_frz_xc",    32'(xc_b), 32'd0);
      check_eq("b_frz_cyc2",  cyc_b, 32'd8);
      en_b = 1'b0; tick();
      check_eq("b_frz_noen",  32'(st_b), 32'd3);
      clr_b = 1'b1; tick();
      check_eq("b_clr_state", 32'(st_b), 32'd0);
      check_eq("b_clr_fail",  32'(fail_b), 32'd0);
      check_eq("b_clr_thr",   32'(thr_b), 32'd0);
      clr_b = 1'b0; rst_b = 1'b1;

      // ================= C: 4-bit counter saturation =================
      rst_c = 1'b0; en_c = 1'b1;
      tick();
      fire_c = 3'b010;
      repeat (20) tick();
      check_eq("c_cov_sat",  32'(cov_c), 32'd15);
      check_eq("c_cyc",      cyc_c, 32'd20);
      check_eq("c_fail",     32'(fail_c), 32'd0);
      check_eq("c_state",    32'(st_c), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
